// File: rtl/vdp_host_pkg.sv
`default_nettype none
// ==========================================================================
// Package  : vdp_host_pkg
// Purpose  : Shared state encoding and mode constants for the VDP host port.
// Revision : 1.0  initial release
// ==========================================================================
package vdp_host_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam logic MODE_DATA = 1'b0;
  localparam logic MODE_CTRL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ==========================================================================
// Module   : sync2
// Purpose  : Two-flop synchroniser with a configurable reset value.
// Revision : 1.0  initial release
// ==========================================================================
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule
`default_nettype wire

// File: rtl/vdp_host_port.sv
`default_nettype none
// ==========================================================================
// Module   : vdp_host_port
// Purpose  : CPU-side initiator turning one-shot requests into stretched,
//            spaced TMS9918 strobes; returns read data and syncs the IRQ.
// Revision : 1.0  initial release
// ==========================================================================
module vdp_host_port
  import vdp_host_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 6,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 8
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       req,
  input  logic       we,
  input  logic       sel_mode,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       irq,
  output logic       vdp_csr_n,
  output logic       vdp_csw_n,
  output logic       vdp_mode,
  output logic [7:0] vdp_cd_o,
  input  logic [7:0] vdp_cd_i,
  input  logic       vdp_int_n
);

  localparam int C_MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int C_MAX_B   = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int C_MAX_CYC = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);

  localparam logic [C_CNT_W-1:0] C_CNT_ONE    = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] C_SETUP_LD   = C_CNT_W'((SETUP_CYC   > 0) ? SETUP_CYC   - 1 : 0);
  localparam logic [C_CNT_W-1:0] C_STROBE_LD  = C_CNT_W'((STROBE_CYC  > 0) ? STROBE_CYC  - 1 : 0);
  localparam logic [C_CNT_W-1:0] C_HOLD_LD    = C_CNT_W'((HOLD_CYC    > 0) ? HOLD_CYC    - 1 : 0);
  localparam logic [C_CNT_W-1:0] C_RECOVER_LD = C_CNT_W'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);

  // Successor of each phase once zero-length phases are skipped
  localparam state_t C_AFTER_IDLE   = (SETUP_CYC > 0) ? SETUP : STROBE;
  localparam state_t C_AFTER_HOLD   = (RECOVER_CYC > 0) ? RECOVER : IDLE;
  localparam state_t C_AFTER_STROBE = (HOLD_CYC > 0) ? HOLD : C_AFTER_HOLD;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_CNT_W-1:0]   w_cnt_ld;
  logic                 w_cnt_zero;
  logic                 w_we_eff;
  logic                 w_done;

  logic                 r_we;
  logic                 r_mode;
  logic [7:0]           r_cd_o;
  logic [7:0]           r_rdata;
  logic                 r_ack;
  logic                 r_csr_n;
  logic                 r_csw_n;
  logic                 w_int_n_sync;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req)        w_state_nxt = C_AFTER_IDLE;
      SETUP:   if (w_cnt_zero) w_state_nxt = STROBE;
      STROBE:  if (w_cnt_zero) w_state_nxt = C_AFTER_STROBE;
      HOLD:    if (w_cnt_zero) w_state_nxt = C_AFTER_HOLD;
      RECOVER: if (w_cnt_zero) w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase

    w_cnt_ld = '0;
    case (w_state_nxt)
      SETUP:   w_cnt_ld = C_SETUP_LD;
      STROBE:  w_cnt_ld = C_STROBE_LD;
      HOLD:    w_cnt_ld = C_HOLD_LD;
      RECOVER: w_cnt_ld = C_RECOVER_LD;
      default: w_cnt_ld = '0;
    endcase

    // In IDLE the command regs are being loaded this edge, so use the live input
    w_we_eff = (r_state == IDLE) ? we : r_we;

    w_done = ((r_state == STROBE) || (r_state == HOLD)) &&
             ((w_state_nxt == RECOVER) || (w_state_nxt == IDLE));
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_mode  <= MODE_DATA;
      r_cd_o  <= 8'h00;
      r_rdata <= 8'h00;
      r_ack   <= 1'b0;
      r_csr_n <= 1'b1;
      r_csw_n <= 1'b1;
    end else begin
      if (w_state_nxt != r_state) begin
        r_cnt <= w_cnt_ld;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - C_CNT_ONE;
      end

      if ((r_state == IDLE) && req) begin
        r_we   <= we;
        r_mode <= sel_mode ? MODE_CTRL : MODE_DATA;
        if (we) begin
          r_cd_o <= wdata;
        end
      end

      r_csw_n <= !((w_state_nxt == STROBE) && w_we_eff);
      r_csr_n <= !((w_state_nxt == STROBE) && !w_we_eff);

      if ((r_state == STROBE) && w_cnt_zero && !r_we) begin
        r_rdata <= vdp_cd_i;
      end

      r_ack <= w_done;
    end
  end

  sync2 #(
    .RST_VAL (1'b1)
  ) u_int_sync (
    .clk   (clk),
    .RESET (RESET),
    .d     (vdp_int_n),
    .q     (w_int_n_sync)
  );

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign busy      = (r_state != IDLE);
  assign irq       = ~w_int_n_sync;
  assign vdp_csr_n = r_csr_n;
  assign vdp_csw_n = r_csw_n;
  assign vdp_mode  = r_mode;
  assign vdp_cd_o  = r_cd_o;

endmodule
`default_nettype wire

// File: tb/tb_vdp_host_port.sv
`default_nettype none
// ==========================================================================
// Module   : tb_vdp_host_port
// Purpose  : Scoreboard bench for vdp_host_port (default and no-setup/hold builds).
// Revision : 1.0  initial release
// ==========================================================================
module tb_vdp_host_port;
  import vdp_host_pkg::*;

  localparam int SETUP   = 2;
  localparam int STROBE_W = 6;
  localparam int HOLDC   = 2;
  localparam int RECOV   = 8;
  localparam int LAT     = 1 + SETUP + STROBE_W + HOLDC;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       req = 1'b0, we = 1'b0, sel_mode = 1'b0;
  logic [7:0] wdata = 8'h00, vdp_cd_i = 8'h00;
  logic       vdp_int_n = 1'b1;
  logic       ack, busy, irq, vdp_csr_n, vdp_csw_n, vdp_mode;
  logic [7:0] rdata, vdp_cd_o;

  logic       req2 = 1'b0, we2 = 1'b0, sel2 = 1'b0;
  logic [7:0] wdata2 = 8'h00, cdi2 = 8'h00;
  logic       ack2, busy2, irq2, csr2_n, csw2_n, mode2;
  logic [7:0] rdata2, cdo2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vdp_host_port dut (
    .clk(clk), .RESET(RESET), .req(req), .we(we), .sel_mode(sel_mode), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .irq(irq), .vdp_csr_n(vdp_csr_n),
    .vdp_csw_n(vdp_csw_n), .vdp_mode(vdp_mode), .vdp_cd_o(vdp_cd_o),
    .vdp_cd_i(vdp_cd_i), .vdp_int_n(vdp_int_n)
  );

  vdp_host_port #(.SETUP_CYC(0), .STROBE_CYC(6), .HOLD_CYC(0), .RECOVER_CYC(8)) dut2 (
    .clk(clk), .RESET(RESET), .req(req2), .we(we2), .sel_mode(sel2), .wdata(wdata2),
    .ack(ack2), .rdata(rdata2), .busy(busy2), .irq(irq2), .vdp_csr_n(csr2_n),
    .vdp_csw_n(csw2_n), .vdp_mode(mode2), .vdp_cd_o(cdo2),
    .vdp_cd_i(cdi2), .vdp_int_n(vdp_int_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected access: strobe kind, mode, bus value, rdata at ack, accept cycle
  typedef struct {
    bit         we;
    bit         sel;
    logic [7:0] cd;
    logic [7:0] rd;
    int         acc_cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] m_last_wr = 8'h00;
  logic [7:0] m_last_rd = 8'h00;

  int run = 0, last_rise = 0;
  bit have_rise = 1'b0;

  // Monitor: samples 2 time units after each rising edge
  always begin
    @(posedge clk);
    #2;
    if (RESET) begin
      run = 0;
      have_rise = 1'b0;
    end else begin
      if (sbq.size() > 0 && cyc > sbq[0].acc_cyc && cyc < sbq[0].acc_cyc + LAT) begin
        check("vdp_mode", vdp_mode, sbq[0].sel);
        check("vdp_cd_o", vdp_cd_o, sbq[0].cd);
      end
      if (!vdp_csw_n || !vdp_csr_n) begin
        if (sbq.size() == 0) begin
          check("strobe_unexpected", 1, 0);
        end else begin
          if (run == 0) begin
            check("strobe_start", cyc - sbq[0].acc_cyc, SETUP + 1);
            if (have_rise)
              check("access_spacing", (cyc - last_rise) >= (RECOV + HOLDC + SETUP + 1), 1);
          end
          check("csw_n", vdp_csw_n, !sbq[0].we);
          check("csr_n", vdp_csr_n, sbq[0].we);
        end
        run++;
      end else if (run > 0) begin
        check("strobe_width", run, STROBE_W);
        last_rise = cyc;
        have_rise = 1'b1;
        run = 0;
      end
      if (ack) begin
        if (sbq.size() == 0) begin
          check("ack_unexpected", 1, 0);
        end else begin
          exp_t h;
          h = sbq.pop_front();
          check("ack_latency", cyc - h.acc_cyc, LAT);
          check("rdata", rdata, h.rd);
        end
      end
    end
  end

  // acc_override >= 0: req is already high, the access starts at that cycle
  task automatic access(input bit w, input bit s, input logic [7:0] d, input logic [7:0] cdi,
                        input bit toggle, input bit keep_req, input int acc_override,
                        output int ack_cyc);
    exp_t e;
    bit   got;
    int   n;
    if (acc_override < 0) begin
      n = 0;
      @(negedge clk);
      while (busy && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (busy) check("idle_timeout", 1, 0);
    end
    req = 1'b1; we = w; sel_mode = s; wdata = d; vdp_cd_i = cdi;
    e.we = w; e.sel = s;
    e.cd = w ? d : m_last_wr;
    e.rd = w ? m_last_rd : cdi;
    e.acc_cyc = (acc_override < 0) ? cyc : acc_override;
    if (w) m_last_wr = d;
    else   m_last_rd = cdi;
    sbq.push_back(e);
    got = 1'b0;
    ack_cyc = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (toggle && cyc == e.acc_cyc + 5) begin
        we = ~we; sel_mode = ~sel_mode; wdata = ~wdata;
      end
      if (ack) begin
        got = 1'b1;
        ack_cyc = cyc;
      end
    end
    if (!got) check("ack_timeout", 0, 1);
    if (!keep_req) req = 1'b0;
  endtask

  task automatic access2(input bit w, input logic [7:0] d, input logic [7:0] cdi);
    int acc, first_low, ack_at, n;
    n = 0;
    @(negedge clk);
    while (busy2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    req2 = 1'b1; we2 = w; sel2 = MODE_DATA; wdata2 = d; cdi2 = cdi;
    acc = cyc; first_low = -1; ack_at = -1;
    for (int i = 0; i < 40 && ack_at < 0; i++) begin
      @(negedge clk);
      if (first_low < 0 && (!csw2_n || !csr2_n)) first_low = cyc;
      if (ack2) ack_at = cyc;
    end
    req2 = 1'b0;
    check("d2_strobe_start", first_low - acc, 1);
    check("d2_ack_latency", ack_at - acc, 7);
    if (w) check("d2_cd_o", cdo2, d);
    else   check("d2_rdata", rdata2, cdi);
  endtask

  initial begin
    int ac, ac2, acks;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_irq", irq, 0);
    check("rst_csr_n", vdp_csr_n, 1);
    check("rst_csw_n", vdp_csw_n, 1);
    check("rst_mode", vdp_mode, MODE_DATA);
    check("rst_cd_o", vdp_cd_o, 8'h00);
    RESET = 1'b0;

    access(1'b1, MODE_CTRL, 8'h8F, 8'h00, 1'b0, 1'b0, -1, ac);
    access(1'b0, MODE_DATA, 8'h00, 8'hA5, 1'b0, 1'b0, -1, ac);
    access(1'b1, MODE_DATA, 8'h55, 8'h00, 1'b0, 1'b1, -1, ac);
    access(1'b1, MODE_DATA, 8'hAA, 8'h00, 1'b0, 1'b0, ac + RECOV, ac2);
    check("b2b_ack_gap", ac2 - ac, RECOV + LAT);
    access(1'b1, MODE_CTRL, 8'h3C, 8'h00, 1'b1, 1'b0, -1, ac);
    access(1'b0, MODE_CTRL, 8'h00, 8'h9E, 1'b1, 1'b0, -1, ac);

    // Reset in the middle of a strobe
    @(negedge clk);
    while (busy) @(negedge clk);
    req = 1'b1; we = 1'b1; sel_mode = MODE_DATA; wdata = 8'h77;
    begin
      exp_t e;
      e.we = 1'b1; e.sel = MODE_DATA; e.cd = 8'h77; e.rd = m_last_rd; e.acc_cyc = cyc;
      sbq.push_back(e);
    end
    repeat (5) @(negedge clk);
    RESET = 1'b1; req = 1'b0;
    sbq.delete();
    m_last_wr = 8'h00; m_last_rd = 8'h00;
    @(negedge clk);
    RESET = 1'b0;
    check("midrst_csw_n", vdp_csw_n, 1);
    check("midrst_csr_n", vdp_csr_n, 1);
    check("midrst_busy", busy, 0);
    check("midrst_cd_o", vdp_cd_o, 8'h00);
    acks = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("midrst_no_ack", acks, 0);
    access(1'b0, MODE_CTRL, 8'h00, 8'h42, 1'b0, 1'b0, -1, ac);

    // Interrupt synchroniser latency
    @(negedge clk); vdp_int_n = 1'b0;
    @(negedge clk); check("irq_set_1cyc", irq, 0);
    @(negedge clk); check("irq_set_2cyc", irq, 1);
    check("irq2_set", irq2, 1);
    vdp_int_n = 1'b1;
    @(negedge clk); check("irq_clr_1cyc", irq, 1);
    @(negedge clk); check("irq_clr_2cyc", irq, 0);

    access2(1'b1, 8'hC3, 8'h00);
    access2(1'b0, 8'h00, 8'h5A);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] d, c;
      d = 8'($urandom);
      c = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      access(1'($urandom), 1'($urandom), d, c, (i % 5) == 0, 1'b0, -1, ac);
    end
    repeat (12) @(negedge clk);
    check("queue_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
